// File: rtl/program_mem_loader_if.sv
// program_mem_loader_if: valid/ready program load port between a host and the instruction RAM
//   start/base/len : host begins a load of len words at word address base (1-cycle pulse)
//   data/valid     : host offers one load word
//   ready          : loader accepts a word this cycle
//   done/error     : 1-cycle pulses when a load finishes or is rejected for range overflow
interface program_mem_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 28
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] len;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  done;
  logic                  error;
  modport master (output start, base, len, data, valid, input ready, done, error);
  modport slave (input start, base, len, data, valid, output ready, done, error);
endinterface

// File: rtl/program_mem_loader.sv
// program_mem_loader: writable instruction RAM with registered fetch port and streaming load port
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   address     : CPU fetch address (PC)
//   instruction : fetched word, one cycle after address; NOP_WORD when busy or out of range
//   busy        : high while the RAM is being NOP-filled or loaded; CPU must hold its PC
//   ld          : host load port (see program_mem_loader_if)
module program_mem_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 28,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 28'h0000FA0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  busy,
  program_mem_loader_if.slave   ld
);
  localparam int                  AI      = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  we;
  logic [AI-1:0]         wa;
  logic [DATA_WIDTH-1:0] wd;
  logic                  in_range;
  logic                  overflow;
  always_comb begin
    we       = state == CLEAR || (state == LOAD && ld.valid && ld.ready);
    wa       = state == CLEAR ? AI'(cnt) : AI'(base_r + cnt);
    wd       = state == CLEAR ? NOP_WORD : ld.data;
    in_range = {1'b0, address} < DEPTH_W;
    // widened by one bit so base+len cannot wrap and slip past the check
    overflow = {1'b0, ld.base} + {1'b0, ld.len} > DEPTH_W;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= CLEAR;
      cnt         <= '0;
      base_r      <= '0;
      len_r       <= '0;
      instruction <= NOP_WORD;
      busy        <= 1'b1;
      ld.ready    <= 1'b0;
      ld.done     <= 1'b0;
      ld.error    <= 1'b0;
    end else begin
      // fetch is masked whenever the RAM is being written, so no partial program is visible
      instruction <= (state == IDLE && in_range) ? mem[address[AI-1:0]] : NOP_WORD;
      ld.done     <= 1'b0;
      ld.error    <= 1'b0;
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE:
          if (ld.start) begin
            if (ld.len == '0) ld.done <= 1'b1;
            else if (overflow) ld.error <= 1'b1;
            else begin
              state    <= LOAD;
              base_r   <= ld.base;
              len_r    <= ld.len;
              cnt      <= '0;
              busy     <= 1'b1;
              ld.ready <= 1'b1;
            end
          end
        LOAD:
          if (ld.valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == len_r - 1'b1) begin
              state    <= IDLE;
              busy     <= 1'b0;
              ld.ready <= 1'b0;
              ld.done  <= 1'b1;
            end
          end
        default: state <= CLEAR;
      endcase
    end
endmodule

// File: tb/tb_program_mem_loader.sv
// tb_program_mem_loader: directed tests with a per-cycle behavioural model of the loader
module tb_program_mem_loader;
  localparam int              AW    = 16;
  localparam int              DW    = 28;
  localparam int              DEPTH = 256;
  localparam logic [DW-1:0]   NOP   = 28'h0000FA0;
  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic          busy;
  int            vectors = 0;
  int            miscompares = 0;
  logic          chk = 1'b0;
  program_mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ld ();
  program_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .address(address), .instruction(instruction), .busy(busy), .ld(ld.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: remaining fill cycles, remaining load words, and a word array
  logic [DW-1:0] mm [DEPTH];
  int            clear_left;
  int            load_rem;
  int            ptr;
  logic [DW-1:0] e_instr;
  logic          e_busy, e_ready, e_done, e_err;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
      clear_left = DEPTH;
      load_rem   = 0;
      e_instr    = NOP;
      e_busy     = 1'b1;
      e_ready    = 1'b0;
      e_done     = 1'b0;
      e_err      = 1'b0;
    end else begin
      e_instr = (clear_left == 0 && load_rem == 0 && int'(address) < DEPTH) ? mm[address] : NOP;
      e_done  = 1'b0;
      e_err   = 1'b0;
      if (clear_left > 0) clear_left--;
      else if (load_rem > 0) begin
        if (ld.valid) begin
          mm[ptr] = ld.data;
          ptr++;
          load_rem--;
          if (load_rem == 0) e_done = 1'b1;
        end
      end else if (ld.start) begin
        if (ld.len == 0) e_done = 1'b1;
        else if (int'(ld.base) + int'(ld.len) > DEPTH) e_err = 1'b1;
        else begin
          ptr      = int'(ld.base);
          load_rem = int'(ld.len);
        end
      end
      e_busy  = clear_left > 0 || load_rem > 0;
      e_ready = load_rem > 0;
    end
  always @(negedge clk)
    if (chk) begin
      check("instruction", 32'(instruction), 32'(e_instr));
      check("busy", 32'(busy), 32'(e_busy));
      check("ready", 32'(ld.ready), 32'(e_ready));
      check("done", 32'(ld.done), 32'(e_done));
      check("error", 32'(ld.error), 32'(e_err));
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
  endtask
  task automatic start_load(input int b, input int l);
    ld.start = 1'b1;
    ld.base  = AW'(b);
    ld.len   = AW'(l);
    tick();
    ld.start = 1'b0;
  endtask
  task automatic fetch(input int a, input logic [DW-1:0] exp, input string name);
    address = AW'(a);
    tick();
    check(name, 32'(instruction), 32'(exp));
  endtask
  int n;
  initial begin
    rst_n    = 1'b0;
    address  = AW'(5);
    ld.start = 1'b0;
    ld.base  = '0;
    ld.len   = '0;
    ld.data  = '0;
    ld.valid = 1'b0;
    tick();
    tick();
    chk = 1'b1;
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_instr", 32'(instruction), 32'h0000FA0);
    rst_n = 1'b1;
    wait_idle(n);
    check("clear_cycles", 32'(n), 32'd256);
    tick();
    check("t1_instr", 32'(instruction), 32'h0000FA0);
    start_load(0, 3);
    ld.valid = 1'b1;
    ld.data = 28'hAAAAAAA;
    tick();
    ld.data = 28'hBBBBBBB;
    tick();
    ld.data = 28'hCCCCCCC;
    tick();
    ld.valid = 1'b0;
    check("t2_done", 32'(ld.done), 32'd1);
    fetch(0, 28'hAAAAAAA, "t2_fetch0");
    fetch(1, 28'hBBBBBBB, "t2_fetch1");
    fetch(2, 28'hCCCCCCC, "t2_fetch2");
    start_load(250, 7);
    check("t3_error", 32'(ld.error), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    fetch(250, NOP, "t3_word250");
    start_load(10, 4);
    for (int i = 0; i < 8; i++) begin
      ld.valid = (i % 2) == 0;
      ld.data  = DW'(100 + i);
      tick();
    end
    ld.valid = 1'b0;
    check("t4_ready", 32'(ld.ready), 32'd0);
    fetch(10, 28'd100, "t4_fetch10");
    fetch(13, 28'd106, "t4_fetch13");
    fetch(14, NOP, "t4_fetch14");
    start_load(5, 0);
    check("len0_done", 32'(ld.done), 32'd1);
    fetch(300, NOP, "t6_addr300");
    start_load(20, 2);
    start_load(0, 1);
    ld.valid = 1'b1;
    ld.data = 28'd7;
    tick();
    ld.data = 28'd8;
    tick();
    ld.valid = 1'b0;
    check("t6_done", 32'(ld.done), 32'd1);
    fetch(20, 28'd7, "t6_fetch20");
    fetch(0, 28'hAAAAAAA, "t6_fetch0");
    start_load(30, 5);
    ld.valid = 1'b1;
    ld.data = 28'd1;
    tick();
    ld.data = 28'd2;
    tick();
    ld.valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("t5_done", 32'(ld.done), 32'd0);
    rst_n = 1'b1;
    wait_idle(n);
    check("t5_clear_cycles", 32'(n), 32'd256);
    fetch(30, NOP, "t5_fetch30");
    fetch(31, NOP, "t5_fetch31");
    fetch(0, NOP, "t5_fetch0");
    tick();
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
